nlc_ch_sequencer: RTL

NLC_CH_SEQUENCER -- requirements
Module: nlc_ch_sequencer

---
 rtl/nlc_pkg.sv | 9 +
 rtl/nlc_result_bank.sv | 16 +
 rtl/nlc_ch_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/nlc_pkg.sv
// nlc_pkg: shared sizes, sequencer states and operation-mode encodings.
package nlc_pkg;
   localparam int NUM_CH = 16;
   localparam int X_W = 21;
   localparam int CNT_W = 5;
   localparam logic [1:0] MODE_ALL = 2'b01;
   localparam logic [1:0] MODE_ONE = 2'b10;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/nlc_result_bank.sv
// nlc_result_bank: NUM_CH x X_W result registers, at most one slot written per cycle.
module nlc_result_bank #(
   parameter int NUM_CH = nlc_pkg::NUM_CH,
   parameter int X_W = nlc_pkg::X_W
) (
   input  logic clk,
   input  logic reset,
   input  logic we,
   input  logic [3:0] idx,
   input  logic [X_W-1:0] din,
   output logic [NUM_CH*X_W-1:0] bank
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) bank <= '0;
      else if (we) bank[idx*X_W +: X_W] <= din;
endmodule

// File: rtl/nlc_ch_sequencer.sv
// nlc_ch_sequencer: issues a frame of ADC channels to the shared NLC datapath
// and collects the in-order results into a registered bank.
module nlc_ch_sequencer #(
   parameter int NUM_CH = nlc_pkg::NUM_CH,
   parameter int X_W = nlc_pkg::X_W
) (
   input  logic clk,
   input  logic reset,
   input  logic srdyi,
   input  logic [1:0] operation_mode_i,
   input  logic [3:0] ch_sel_i,
   input  logic [NUM_CH*X_W-1:0] x_adc_i,
   output logic dp_srdyi,
   output logic [3:0] dp_ch_o,
   output logic [X_W-1:0] dp_x_adc_o,
   input  logic dp_srdyo,
   input  logic [X_W-1:0] dp_x_lin_i,
   output logic [NUM_CH*X_W-1:0] x_lin_o,
   output logic srdyo,
   output logic busy_o,
   input  logic clr_err_i,
   output logic err_ovr_o,
   output logic err_unexp_o
);
   import nlc_pkg::*;
   state_t state, state_nx;
   logic [NUM_CH*X_W-1:0] x_frm;
   logic [1:0] mode_frm;
   logic [3:0] sel_frm, ret_ch;
   logic [CNT_W-1:0] iss_cnt, ret_cnt, exp_cnt;
   logic single, start, iss_last, ret_ok, ret_last;

   assign single = mode_frm == MODE_ONE;
   assign exp_cnt = single ? CNT_W'(1) : CNT_W'(NUM_CH);
   assign start = srdyi && (operation_mode_i == MODE_ALL || operation_mode_i == MODE_ONE);
   assign iss_last = single || iss_cnt == CNT_W'(NUM_CH - 1);
   // A return is only owed while a frame is open and short of its count.
   assign ret_ok = dp_srdyo && (state == ISSUE || state == DRAIN) && ret_cnt != exp_cnt;
   assign ret_last = ret_ok && ret_cnt + CNT_W'(1) == exp_cnt;
   assign ret_ch = single ? sel_frm : ret_cnt[3:0];

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? ISSUE : IDLE;
         ISSUE:   state_nx = ret_last ? DONE : iss_last ? DRAIN : ISSUE;
         DRAIN:   state_nx = ret_last ? DONE : DRAIN;
         default: state_nx = IDLE;
      endcase
      dp_srdyi = state == ISSUE;
      dp_ch_o = dp_srdyi ? (single ? sel_frm : iss_cnt[3:0]) : 4'd0;
      dp_x_adc_o = dp_srdyi ? x_frm[dp_ch_o*X_W +: X_W] : '0;
      srdyo = state == DONE;
      busy_o = state != IDLE;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         x_frm <= '0;
         mode_frm <= '0;
         sel_frm <= '0;
         iss_cnt <= '0;
         ret_cnt <= '0;
         err_ovr_o <= 1'b0;
         err_unexp_o <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            x_frm <= x_adc_i;
            mode_frm <= operation_mode_i;
            sel_frm <= ch_sel_i;
            iss_cnt <= '0;
            ret_cnt <= '0;
         end else begin
            iss_cnt <= iss_cnt + CNT_W'(dp_srdyi);
            ret_cnt <= ret_cnt + CNT_W'(ret_ok);
         end
         err_ovr_o <= (srdyi && busy_o) || (err_ovr_o && !clr_err_i);
         err_unexp_o <= (dp_srdyo && !ret_ok) || (err_unexp_o && !clr_err_i);
      end

   nlc_result_bank #(.NUM_CH(NUM_CH), .X_W(X_W)) u_bank (
      .clk(clk),
      .reset(reset),
      .we(ret_ok),
      .idx(ret_ch),
      .din(dp_x_lin_i),
      .bank(x_lin_o)
   );
endmodule
